// File: rtl/mage_pkg.sv
// Shared types and default geometry for the MAGE scratchpad port.
package mage_pkg;

    localparam int unsigned DEF_N_AGE              = 4;
    localparam int unsigned N_BANKS_PER_STREAM     = 4;
    localparam int unsigned DEF_NBIT_ADDR          = 10;
    localparam int unsigned DEF_DATA_W             = 32;
    localparam int unsigned DEF_NBIT_CNT           = 16;
    localparam int unsigned LOG_N_BANKS_PER_STREAM = $clog2(N_BANKS_PER_STREAM);

    // One AGE request as issued by MAGE for a stream.
    typedef struct packed {
        logic                          valid;
        logic                          lns;
        logic [DEF_NBIT_ADDR-1:0]      addr;
        logic [N_BANKS_PER_STREAM-1:0] bank;
        logic [DEF_DATA_W-1:0]         wdata;
    } spm_req_t;

endpackage

// File: rtl/mage_spm_bank_arb.sv
// Fixed-priority arbiter for one bank: lowest AGE index wins, all others lose.
module mage_spm_bank_arb
    import mage_pkg::*;
#(
    parameter int unsigned N_AGE = DEF_N_AGE
) (
    input  logic [N_AGE-1:0] req_i,
    output logic [N_AGE-1:0] gnt_c_o,
    output logic [N_AGE-1:0] lose_c_o
);

    logic found;

    always_comb begin
        gnt_c_o = '0;
        found   = 1'b0;
        for (int unsigned a = 0; a < N_AGE; a++) begin
            if (req_i[a] && !found) begin
                gnt_c_o[a] = 1'b1;
                found      = 1'b1;
            end
        end
        lose_c_o = req_i & ~gnt_c_o;
    end

endmodule

// File: rtl/mage_spm_port.sv
// Bank-side responder for one MAGE stream: decode, per-bank arbitration,
// SRAM drive, fixed-latency load return, sticky status and access counters.
module mage_spm_port
    import mage_pkg::*;
#(
    parameter int unsigned N_AGE     = DEF_N_AGE,
    parameter int unsigned N_BANKS   = N_BANKS_PER_STREAM,
    parameter int unsigned NBIT_ADDR = DEF_NBIT_ADDR,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned NBIT_CNT  = DEF_NBIT_CNT
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           clear_i,
    input  logic [N_AGE-1:0]               age_valid_i,
    input  logic [N_AGE-1:0]               age_lns_i,
    input  logic [N_AGE*NBIT_ADDR-1:0]     age_addr_i,
    input  logic [N_AGE*N_BANKS-1:0]       age_bank_i,
    input  logic [N_AGE*DATA_W-1:0]        age_wdata_i,
    output logic [N_BANKS-1:0]             bank_req_o,
    output logic [N_BANKS-1:0]             bank_we_o,
    output logic [N_BANKS*NBIT_ADDR-1:0]   bank_addr_o,
    output logic [N_BANKS*DATA_W-1:0]      bank_wdata_o,
    input  logic [N_BANKS*DATA_W-1:0]      bank_rdata_i,
    output logic [N_AGE*DATA_W-1:0]        age_rdata_o,
    output logic [N_AGE-1:0]               age_rvalid_o,
    output logic                           conflict_o,
    output logic [N_AGE-1:0]               conflict_age_o,
    output logic                           onehot_err_o,
    output logic [NBIT_CNT-1:0]            n_loads_o,
    output logic [NBIT_CNT-1:0]            n_stores_o
);

    localparam int unsigned LOG_NB = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
    localparam int unsigned POP_W  = $clog2(N_AGE + 1);
    localparam int unsigned SUM_W  = NBIT_CNT + 1;

    logic [N_AGE-1:0]          legal_c, illegal_c, age_gnt_c, lose_c;
    logic [N_AGE-1:0]          bank_reqv_c [N_BANKS];
    logic [N_AGE-1:0]          bank_gnt_c  [N_BANKS];
    logic [N_AGE-1:0]          bank_lose_c [N_BANKS];
    logic [N_AGE*LOG_NB-1:0]   tag_bank_d, tag_bank_q;
    logic [N_AGE-1:0]          tag_vld_d, tag_vld_q;
    logic [N_AGE*DATA_W-1:0]   rdata_d, rdata_q;
    logic [N_AGE-1:0]          rvalid_q, conf_age_q;
    logic                      conf_q, err_q;
    logic [NBIT_CNT-1:0]       n_ld_q, n_st_q;
    logic [POP_W-1:0]          n_ld_c, n_st_c;

    function automatic logic [NBIT_CNT-1:0] sat_add(input logic [NBIT_CNT-1:0] c,
                                                    input logic [POP_W-1:0] n);
        logic [SUM_W-1:0] s;
        s = SUM_W'(c) + SUM_W'(n);
        return s[NBIT_CNT] ? '1 : s[NBIT_CNT-1:0];
    endfunction

    // Decode: legality, bank index for the tag, per-bank request vectors.
    always_comb begin
        legal_c    = '0;
        illegal_c  = '0;
        tag_bank_d = '0;
        for (int unsigned a = 0; a < N_AGE; a++) begin
            legal_c[a]   = age_valid_i[a] && $onehot(age_bank_i[a*N_BANKS +: N_BANKS]);
            illegal_c[a] = age_valid_i[a] && !legal_c[a];
            for (int unsigned b = 0; b < N_BANKS; b++) begin
                if (age_bank_i[a*N_BANKS + b]) tag_bank_d[a*LOG_NB +: LOG_NB] = LOG_NB'(b);
            end
        end
        for (int unsigned b = 0; b < N_BANKS; b++) begin
            for (int unsigned a = 0; a < N_AGE; a++) begin
                bank_reqv_c[b][a] = legal_c[a] & age_bank_i[a*N_BANKS + b];
            end
        end
    end

    for (genvar b = 0; b < N_BANKS; b++) begin : g_arb
        mage_spm_bank_arb #(.N_AGE(N_AGE)) u_arb (
            .req_i    (bank_reqv_c[b]),
            .gnt_c_o  (bank_gnt_c[b]),
            .lose_c_o (bank_lose_c[b])
        );
    end

    // Bank drive muxes; ungranted banks stay fully zero.
    always_comb begin
        bank_req_o   = '0;
        bank_we_o    = '0;
        bank_addr_o  = '0;
        bank_wdata_o = '0;
        age_gnt_c    = '0;
        lose_c       = '0;
        for (int unsigned b = 0; b < N_BANKS; b++) begin
            age_gnt_c = age_gnt_c | bank_gnt_c[b];
            lose_c    = lose_c | bank_lose_c[b];
            for (int unsigned a = 0; a < N_AGE; a++) begin
                if (bank_gnt_c[b][a]) begin
                    bank_req_o[b] = 1'b1;
                    bank_we_o[b]  = ~age_lns_i[a];
                    bank_addr_o[b*NBIT_ADDR +: NBIT_ADDR] = age_addr_i[a*NBIT_ADDR +: NBIT_ADDR];
                    bank_wdata_o[b*DATA_W +: DATA_W]      = age_wdata_i[a*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Granted-access popcounts and the load return mux.
    always_comb begin
        n_ld_c    = '0;
        n_st_c    = '0;
        tag_vld_d = age_gnt_c & age_lns_i;
        rdata_d   = rdata_q;
        for (int unsigned a = 0; a < N_AGE; a++) begin
            if (age_gnt_c[a] && age_lns_i[a])  n_ld_c = n_ld_c + POP_W'(1);
            if (age_gnt_c[a] && !age_lns_i[a]) n_st_c = n_st_c + POP_W'(1);
            if (tag_vld_q[a]) begin
                for (int unsigned b = 0; b < N_BANKS; b++) begin
                    if (tag_bank_q[a*LOG_NB +: LOG_NB] == LOG_NB'(b))
                        rdata_d[a*DATA_W +: DATA_W] = bank_rdata_i[b*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tag_vld_q  <= '0;
            tag_bank_q <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
            conf_q     <= 1'b0;
            conf_age_q <= '0;
            err_q      <= 1'b0;
            n_ld_q     <= '0;
            n_st_q     <= '0;
        end else begin
            tag_vld_q  <= tag_vld_d;
            tag_bank_q <= tag_bank_d;
            rvalid_q   <= tag_vld_q;
            rdata_q    <= rdata_d;
            // Clear wins over any event in the same cycle.
            if (clear_i) begin
                conf_q     <= 1'b0;
                conf_age_q <= '0;
                err_q      <= 1'b0;
                n_ld_q     <= '0;
                n_st_q     <= '0;
            end else begin
                conf_q     <= conf_q | (|lose_c);
                conf_age_q <= conf_age_q | lose_c;
                err_q      <= err_q | (|illegal_c);
                n_ld_q     <= sat_add(n_ld_q, n_ld_c);
                n_st_q     <= sat_add(n_st_q, n_st_c);
            end
        end
    end

    assign age_rdata_o    = rdata_q;
    assign age_rvalid_o   = rvalid_q;
    assign conflict_o     = conf_q;
    assign conflict_age_o = conf_age_q;
    assign onehot_err_o   = err_q;
    assign n_loads_o      = n_ld_q;
    assign n_stores_o     = n_st_q;

endmodule

// File: tb/tb_mage_spm_port.sv
// Randomized self-checking bench for mage_spm_port against a cycle-level reference model.
module tb_mage_spm_port;

    localparam int NA = 4;
    localparam int NB = 4;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int CW = 16;
    localparam int SW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, clear;
    logic [NA-1:0]     valid, lns;
    logic [NA*AW-1:0]  addr;
    logic [NA*NB-1:0]  bank;
    logic [NA*DW-1:0]  wdata;
    logic [NB-1:0]     bank_req, bank_we;
    logic [NB*AW-1:0]  bank_addr;
    logic [NB*DW-1:0]  bank_wdata, bank_rdata;
    logic [NA*DW-1:0]  age_rdata;
    logic [NA-1:0]     age_rvalid, conf_age;
    logic              conf, oherr;
    logic [CW-1:0]     n_ld, n_st;

    logic [NB-1:0]     s_req, s_we;
    logic [NB*AW-1:0]  s_addr;
    logic [NB*DW-1:0]  s_wdata;
    logic [NA*DW-1:0]  s_rdata;
    logic [NA-1:0]     s_rvalid, s_conf_age;
    logic              s_conf, s_err;
    logic [SW-1:0]     s_nld, s_nst;

    mage_spm_port dut (
        .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear),
        .age_valid_i(valid), .age_lns_i(lns), .age_addr_i(addr), .age_bank_i(bank), .age_wdata_i(wdata),
        .bank_req_o(bank_req), .bank_we_o(bank_we), .bank_addr_o(bank_addr), .bank_wdata_o(bank_wdata),
        .bank_rdata_i(bank_rdata), .age_rdata_o(age_rdata), .age_rvalid_o(age_rvalid),
        .conflict_o(conf), .conflict_age_o(conf_age), .onehot_err_o(oherr),
        .n_loads_o(n_ld), .n_stores_o(n_st)
    );

    mage_spm_port #(.NBIT_CNT(SW)) dut_sat (
        .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear),
        .age_valid_i(valid), .age_lns_i(lns), .age_addr_i(addr), .age_bank_i(bank), .age_wdata_i(wdata),
        .bank_req_o(s_req), .bank_we_o(s_we), .bank_addr_o(s_addr), .bank_wdata_o(s_wdata),
        .bank_rdata_i(bank_rdata), .age_rdata_o(s_rdata), .age_rvalid_o(s_rvalid),
        .conflict_o(s_conf), .conflict_age_o(s_conf_age), .onehot_err_o(s_err),
        .n_loads_o(s_nld), .n_stores_o(s_nst)
    );

    // SRAM bank model (one-cycle read latency) and the bench's shadow copy.
    logic [DW-1:0] bmem [NB][1<<AW];
    logic [DW-1:0] smem [NB][1<<AW];
    logic [DW-1:0] brd  [NB];

    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (bank_req[b] === 1'b1) begin
                if (bank_we[b]) bmem[b][bank_addr[b*AW +: AW]] = bank_wdata[b*DW +: DW];
                else            brd[b] <= bmem[b][bank_addr[b*AW +: AW]];
            end
        end
    end

    always_comb begin
        for (int b = 0; b < NB; b++) bank_rdata[b*DW +: DW] = brd[b];
    end

    int n_checks = 0;
    int n_errors = 0;
    int rv_seen  = 0;

    bit            m_conf, m_err;
    logic [NA-1:0] m_cage;
    int            m_nl, m_ns;
    logic [NA-1:0] p1_rv, p2_rv;
    logic [DW-1:0] p1_rd [NA];
    logic [DW-1:0] p2_rd [NA];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int c, input int w);
        return (c > (1 << w) - 1) ? (1 << w) - 1 : c;
    endfunction

    task automatic model_reset();
        m_conf = 0; m_err = 0; m_cage = '0; m_nl = 0; m_ns = 0;
        p1_rv = '0; p2_rv = '0;
    endtask

    // One cycle: drive, check registered state of earlier cycles, predict this cycle.
    task automatic step(input logic [NA-1:0] v, input logic [NA-1:0] l, input logic [NA*AW-1:0] ad,
                        input logic [NA*NB-1:0] bk, input logic [NA*DW-1:0] wd, input logic clr);
        int            owner [NB];
        int            ones, bi, nl, ns, a;
        bit            e_err;
        logic [NB-1:0] e_req, e_we;
        logic [NA-1:0] e_rv, e_lose;
        logic [DW-1:0] e_rd [NA];
        logic [AW-1:0] ea;
        @(posedge clk); #1;
        valid = v; lns = l; addr = ad; bank = bk; wdata = wd; clear = clr;
        #1;
        chk("rvalid", 64'(age_rvalid), 64'(p2_rv));
        for (int k = 0; k < NA; k++) begin
            if (age_rvalid[k] === 1'b1) rv_seen++;
            if (p2_rv[k]) chk($sformatf("rdata%0d", k), 64'(age_rdata[k*DW +: DW]), 64'(p2_rd[k]));
        end
        chk("conflict", 64'(conf), 64'(m_conf));
        chk("conflict_age", 64'(conf_age), 64'(m_cage));
        chk("onehot_err", 64'(oherr), 64'(m_err));
        chk("n_loads", 64'(n_ld), 64'(sat(m_nl, CW)));
        chk("n_stores", 64'(n_st), 64'(sat(m_ns, CW)));
        chk("sat_n_loads", 64'(s_nld), 64'(sat(m_nl, SW)));
        chk("sat_n_stores", 64'(s_nst), 64'(sat(m_ns, SW)));

        e_err = 0; e_lose = '0; e_req = '0; e_we = '0; e_rv = '0; nl = 0; ns = 0;
        for (int b = 0; b < NB; b++) owner[b] = -1;
        for (int k = 0; k < NA; k++) begin
            e_rd[k] = '0;
            if (v[k]) begin
                ones = 0; bi = 0;
                for (int b = 0; b < NB; b++) if (bk[k*NB + b]) begin ones++; bi = b; end
                if (ones != 1)          e_err = 1;
                else if (owner[bi] < 0) owner[bi] = k;
                else                    e_lose[k] = 1'b1;
            end
        end
        for (int b = 0; b < NB; b++) begin
            if (owner[b] >= 0) begin
                a = owner[b];
                ea = ad[a*AW +: AW];
                e_req[b] = 1'b1;
                e_we[b]  = ~l[a];
                chk($sformatf("bank_addr%0d", b), 64'(bank_addr[b*AW +: AW]), 64'(ea));
                chk($sformatf("bank_wdata%0d", b), 64'(bank_wdata[b*DW +: DW]), 64'(wd[a*DW +: DW]));
                if (l[a]) begin
                    e_rv[a] = 1'b1; e_rd[a] = smem[b][ea]; nl++;
                end else begin
                    smem[b][ea] = wd[a*DW +: DW]; ns++;
                end
            end else begin
                chk($sformatf("idle_bank%0d", b), {24'd0, bank_addr[b*AW +: AW], bank_wdata[b*DW +: DW]}, 64'd0);
            end
        end
        chk("bank_req", 64'(bank_req), 64'(e_req));
        chk("bank_we", 64'(bank_we), 64'(e_we));

        if (clr) begin
            m_conf = 0; m_err = 0; m_cage = '0; m_nl = 0; m_ns = 0;
        end else begin
            m_conf = m_conf | (|e_lose);
            m_cage = m_cage | e_lose;
            m_err  = m_err | e_err;
            m_nl   = m_nl + nl;
            m_ns   = m_ns + ns;
        end
        p2_rv = p1_rv; p1_rv = e_rv;
        for (int k = 0; k < NA; k++) begin p2_rd[k] = p1_rd[k]; p1_rd[k] = e_rd[k]; end
    endtask

    task automatic idle();
        step('0, '0, '0, '0, '0, 1'b0);
    endtask

    // Reset asserted and released within one cycle; registered outputs must read zero.
    task automatic reset_pulse();
        @(posedge clk); #1;
        rst_n = 1'b0;
        valid = '0; lns = '0; addr = '0; bank = '0; wdata = '0; clear = 1'b0;
        #2;
        chk("rst_rvalid", 64'(age_rvalid), 64'd0);
        chk("rst_rdata0", 64'(age_rdata[DW-1:0]), 64'd0);
        chk("rst_flags", 64'({conf, conf_age, oherr}), 64'd0);
        chk("rst_counts", 64'({n_ld, n_st}), 64'd0);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [NA-1:0]    v, l;
        logic [NA*AW-1:0] ad;
        logic [NA*NB-1:0] bk;
        logic [NA*DW-1:0] wd;
        logic [NB-1:0]    oh;
        int               rv_base;

        rst_n = 1'b0; clear = 1'b0;
        valid = '0; lns = '0; addr = '0; bank = '0; wdata = '0;
        for (int b = 0; b < NB; b++) begin
            brd[b] = '0;
            for (int k = 0; k < (1 << AW); k++) begin
                bmem[b][k] = {8'(b), 14'(k), 10'(k * 7 + b)};
                smem[b][k] = bmem[b][k];
            end
        end
        bmem[2][10'h15] = 32'hDEADBEEF;
        smem[2][10'h15] = 32'hDEADBEEF;
        model_reset();
        repeat (2) @(posedge clk);
        reset_pulse();

        // Single load: AGE0, bank 2, addr 0x15.
        ad = '0; ad[AW-1:0] = 10'h15; bk = '0; bk[NB-1:0] = 4'b0100;
        step(4'b0001, 4'b0001, ad, bk, '0, 1'b0);
        idle(); idle();
        chk("single_nloads", 64'(n_ld), 64'd1);

        // Store: AGE1 stores 0x1234 to bank 0, addr 3.
        ad = '0; ad[AW +: AW] = 10'd3; bk = '0; bk[NB +: NB] = 4'b0001;
        wd = '0; wd[DW +: DW] = 32'h1234;
        step(4'b0010, 4'b0000, ad, bk, wd, 1'b0);
        idle();
        chk("store_nstores", 64'(n_st), 64'd1);

        // Conflict: AGE1 and AGE3 load bank 1.
        ad = '0; ad[AW +: AW] = 10'd40; ad[3*AW +: AW] = 10'd41;
        bk = '0; bk[NB +: NB] = 4'b0010; bk[3*NB +: NB] = 4'b0010;
        step(4'b1010, 4'b1010, ad, bk, '0, 1'b0);
        idle(); idle();
        chk("conflict_set", 64'(conf), 64'd1);
        chk("conflict_mask", 64'(conf_age), 64'b1000);

        // Illegal bank vector, then clear.
        bk = '0; bk[NB-1:0] = 4'b0110;
        step(4'b0001, 4'b0001, '0, bk, '0, 1'b0);
        idle();
        chk("onehot_err_set", 64'(oherr), 64'd1);
        step('0, '0, '0, '0, '0, 1'b1);
        idle();
        chk("flags_cleared", 64'({conf, conf_age, oherr}), 64'd0);

        // Streaming: four AGEs on four distinct banks for 100 cycles.
        step('0, '0, '0, '0, '0, 1'b1);
        rv_base = rv_seen;
        for (int i = 0; i < 100; i++) begin
            for (int k = 0; k < NA; k++) begin
                ad[k*AW +: AW] = 10'($urandom_range(0, (1 << AW) - 1));
                bk[k*NB +: NB] = 4'(1 << ((k + i) % NB));
            end
            step(4'b1111, 4'b1111, ad, bk, '0, 1'b0);
        end
        idle(); idle();
        chk("stream_rvalids", 64'(rv_seen - rv_base), 64'd400);
        chk("stream_nloads", 64'(n_ld), 64'd400);

        // Saturation on the narrow-counter instance.
        step('0, '0, '0, '0, '0, 1'b1);
        bk = '0; bk[NB-1:0] = 4'b0001;
        for (int i = 0; i < 20; i++) step(4'b0001, 4'b0001, '0, bk, '0, 1'b0);
        idle();
        chk("sat_nloads_15", 64'(s_nld), 64'd15);
        chk("wide_nloads_20", 64'(n_ld), 64'd20);

        // Reset right after a load must swallow its return.
        step(4'b0001, 4'b0001, '0, bk, '0, 1'b0);
        reset_pulse();
        idle();
        chk("no_rvalid_after_rst", 64'(age_rvalid), 64'd0);
        idle();

        // Random traffic, including illegal vectors and occasional clears.
        for (int i = 0; i < 2000; i++) begin
            v = 4'($urandom); l = 4'($urandom);
            for (int k = 0; k < NA; k++) begin
                ad[k*AW +: AW] = 10'($urandom_range(0, 63));
                wd[k*DW +: DW] = $urandom;
                oh = 4'(1 << $urandom_range(0, NB - 1));
                if ($urandom_range(0, 15) == 0) oh = 4'($urandom);
                bk[k*NB +: NB] = oh;
            end
            step(v, l, ad, bk, wd, ($urandom_range(0, 31) == 0));
        end
        idle(); idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mage_spm_port.md
# mage_spm_port

Bank-side responder for one MAGE stream. Each cycle it accepts the per-AGE address, one-hot bank, valid and load/store requests that MAGE issues for that stream, and arbitrates them onto the stream's scratchpad banks. It drives the single-port SRAM bank interfaces and returns load data to each requesting AGE with a fixed latency. It keeps sticky conflict and error status plus saturating access counters for the host. One instance sits between MAGE and the SpM banks for each of the N_STREAMS streams.

## Interface
- N_AGE, default 4: AGEs per stream (N_AGE_PER_STREAM).
- N_BANKS, default 4: banks per stream (N_BANKS_PER_STREAM).
- NBIT_ADDR, default 10: bank word address width.
- DATA_W, default 32: data word width.
- NBIT_CNT, default 16: counter width.
- clk_i  in  1  clock.
- rst_n_i  in  1  reset. Asynchronous and active-low.
- clear_i  in  1  synchronous clear of sticky flags and counters.
- age_valid_i  in  N_AGE  request valid per AGE.
- age_lns_i  in  N_AGE  1 = load, 0 = store.
- age_addr_i  in  N_AGE×NBIT_ADDR  word address within the bank.
- age_bank_i  in  N_AGE×N_BANKS  one-hot target bank.
- age_wdata_i  in  N_AGE×DATA_W  store data.
- bank_req_o  out  N_BANKS  bank access strobe.
- bank_we_o  out  N_BANKS  1 = write.
- bank_addr_o  out  N_BANKS×NBIT_ADDR  bank address.
- bank_wdata_o  out  N_BANKS×DATA_W  write data.
- bank_rdata_i  in  N_BANKS×DATA_W  read data, valid one cycle after a read strobe.
- age_rdata_o  out  N_AGE×DATA_W  returned load data.
- age_rvalid_o  out  N_AGE  load data valid.
- conflict_o  out  1  sticky: at least one request lost arbitration.
- conflict_age_o  out  N_AGE  sticky mask of the losing AGEs.
- onehot_err_o  out  1  sticky: a valid request carried a zero or multi-hot bank vector.
- n_loads_o, n_stores_o  out  NBIT_CNT  granted-access counters, each saturating at all-ones.

## Operation
- Request decode:
  - A request is legal when age_valid_i=1 and age_bank_i has exactly one bit set.
  - A valid request with an illegal bank vector is dropped and sets onehot_err_o. No bank access and no rvalid result from it.
- Arbitration:
  - Each bank is arbitrated independently with fixed priority; the lowest AGE index wins.
  - Every loser is dropped. This applies to loads and stores alike, because MAGE has no backpressure.
  - Each loser sets conflict_o and its own bit in conflict_age_o.
- Bank drive:
  - The bank ports are combinational from the inputs.
  - For a granted request: bank_req_o=1, bank_we_o=~lns, bank_addr_o=addr, and bank_wdata_o=wdata of the winner.
  - Banks with no grant drive req=0 and we=0; addr and wdata are 0.
- Load return:
  - A one-stage tag register holds, per AGE, the granted-load flag and the bank index (log2 N_BANKS bits).
  - In the following cycle, bank_rdata_i[tag] is muxed and registered into age_rdata_o, and age_rvalid_o is set.
- Counters:
  - n_loads_o and n_stores_o add the number of granted loads and stores each cycle, taken as a popcount and added in a single operation.
  - Both saturate at all-ones.
- clear_i clears conflict_o, conflict_age_o, onehot_err_o and both counters.
  - If clear_i coincides with a new event, the clear wins and the event in that same cycle is lost.
  - clear_i does not affect the load pipeline.

## Timing
- A request presented in cycle T drives the bank ports in cycle T.
- For a load granted in T:
  - bank_rdata_i is sampled in T+1.
  - age_rdata_o and age_rvalid_o are valid in T+2, for one cycle.
- Loads are fully pipelined: back-to-back loads in T and T+1 return in T+2 and T+3.
- A store granted in T completes in T. It produces no response.
- Sticky flags and counters update at the clock edge that ends cycle T. They are visible from T+1.
- Reset values:
  - All registered outputs are 0: age_rdata_o, age_rvalid_o, the sticky flags and the counters.
  - The tag register is 0.
  - Asserting reset mid-operation discards any in-flight load, and no rvalid follows release.
- A read and a write to the same bank in the same cycle cannot occur, because only one grant exists per bank.

## Structure
- The following go in mage_pkg:
  - a spm_req_t struct {valid, lns, addr, bank, wdata};
  - the constant LOG_N_BANKS_PER_STREAM.
- Sub-module: mage_spm_bank_arb, one instance per bank. It takes the N_AGE request vector for its bank and produces a one-hot grant plus a loser mask.
- The top level contains:
  - the decode;
  - the bank drive muxes;
  - the tag register;
  - the return mux;
  - the sticky flags and counters.

## Test plan
- Single load: AGE0 loads bank 2, addr 0x15; the bank model returns 0xDEADBEEF. Required: bank_req_o=0b0100 in T, age_rdata_o[0]=0xDEADBEEF with age_rvalid_o=0b0001 in T+2, n_loads_o=1.
- Store: AGE1 stores 0x1234 to bank 0, addr 3. Required: bank_we_o[0]=1, bank_wdata_o[0]=0x1234, n_stores_o=1, no rvalid.
- Conflict: AGE1 and AGE3 both load bank 1. Required: AGE1 is granted and returns data in T+2; conflict_o=1; conflict_age_o=0b1000; AGE3 gets no rvalid.
- Illegal bank vector: age_bank_i=0b0110 with valid. Required: no bank strobe, onehot_err_o=1; after clear_i, all flags are 0.
- Streaming: four AGEs load four distinct banks for 100 consecutive cycles. Required: 400 rvalids, each returning the correct bank data, and n_loads_o=400.
- Saturation and reset:
  - With NBIT_CNT=4, 20 loads leave n_loads_o=15.
  - Asserting rst_n_i in T+1 after a load in T gives no rvalid in T+2.
